param_dm_cache: RTL and testbench

- Parametrised direct-mapped, write-back, write-allocate data cache. One word per line.
- Sits between the MEM stage of the pipelined processor and the backing data memory.
- Replaces the fixed 8-bit/32-bit cache and its tri-state data bus with:
  - separate read and write data buses,
  - a miss/stall output,
  - a req/ack refill and writeback port toward memory,
  - saturating hit/miss performance counters.

---
 rtl/param_dm_cache.sv | 154 +++++++++++++++
 tb/tb_param_dm_cache.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/param_dm_cache.sv
// Direct-mapped, write-back, write-allocate data cache with one word per line.
// Loads that hit return data combinationally. Misses stall the CPU while a
// registered req/ack port first writes back the dirty victim line (if there
// is one) and then refills the line. Hit and miss counters saturate.
module param_dm_cache #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chipSel,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              miss,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

  state_t                         state_q, state_d;
  logic [LINES-1:0]               valid_q, valid_d, dirty_q, dirty_d;
  logic [LINES-1:0][TAG_W-1:0]    tag_q, tag_d;
  logic [LINES-1:0][DATA_W-1:0]   data_q, data_d;
  logic                           mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]              mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]              mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]               hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   atag;
  logic               hit, ack;

  assign idx  = addr[INDEX_W-1:0];
  assign atag = addr[ADDR_W-1:INDEX_W];
  assign hit  = valid_q[idx] & (tag_q[idx] == atag);
  // An ack is only meaningful while a request is actually outstanding.
  assign ack  = mem_ack & mem_req_q;

  assign miss      = (chipSel & ~hit) | (state_q != IDLE);
  assign rdata     = hit ? data_q[idx] : '0;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  // Next-state, line update and memory-port request generation.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    data_d      = data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    case (state_q)
      IDLE: begin
        if (chipSel) begin
          if (hit) begin
            if (write) begin
              data_d[idx]  = wdata;
              dirty_d[idx] = 1'b1;
            end
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
          end else begin
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
            mem_req_d = 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
              // Victim is dirty: push it out before fetching the new line.
              state_d     = WB;
              mem_we_d    = 1'b1;
              mem_addr_d  = {tag_q[idx], idx};
              mem_wdata_d = data_q[idx];
            end else begin
              state_d    = REFILL;
              mem_we_d   = 1'b0;
              mem_addr_d = addr;
            end
          end
        end
      end
      WB: begin
        if (ack) begin
          // Request stays up and turns straight into the refill read.
          dirty_d[idx] = 1'b0;
          state_d      = REFILL;
          mem_we_d     = 1'b0;
          mem_addr_d   = addr;
        end
      end
      REFILL: begin
        if (ack) begin
          data_d[idx]  = mem_rdata;
          tag_d[idx]   = atag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = IDLE;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, line status bits, memory port and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_param_dm_cache.sv
// Directed bench for param_dm_cache: a behavioural memory acks two cycles
// after each request. A second instance with 2-bit counters runs in lockstep
// on the same inputs to exercise counter saturation.
module tb_param_dm_cache;
  logic        clk = 0, rst = 0;
  logic        chipSel = 0, write = 0;
  logic [7:0]  addr = 0;
  logic [31:0] wdata = 0, mem_rdata = 0;
  logic        mem_ack = 0;
  logic [31:0] rdata, mem_wdata;
  logic        miss, mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] hit_cnt, miss_cnt;
  logic [31:0] s_rdata, s_mem_wdata;
  logic        s_miss, s_mem_req, s_mem_we;
  logic [7:0]  s_mem_addr;
  logic [1:0]  s_hit_cnt, s_miss_cnt;

  int total = 0, bad = 0;
  logic [31:0] mem [256];
  bit   model_en = 1;
  int   mcnt = 0, wb_n = 0, rf_n = 0;
  logic [7:0]  last_wb_addr = 0, last_rf_addr = 0;
  logic [31:0] last_wb_data = 0;

  always #5 clk = ~clk;

  param_dm_cache #(.ADDR_W(8), .DATA_W(32), .INDEX_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .chipSel(chipSel), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .miss(miss), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  param_dm_cache #(.ADDR_W(8), .DATA_W(32), .INDEX_W(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .chipSel(chipSel), .write(write), .addr(addr), .wdata(wdata),
    .rdata(s_rdata), .miss(s_miss), .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt));

  // Memory model: sees registered request just after the edge, acks on the second cycle.
  always @(posedge clk) begin
    #1;
    if (!model_en) mcnt = 0;
    else if (mem_ack) begin mem_ack = 0; mcnt = 0; end
    else if (mem_req) begin
      mcnt++;
      if (mcnt == 2) begin
        mem_ack = 1;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata; wb_n++; last_wb_addr = mem_addr; last_wb_data = mem_wdata;
        end else begin
          mem_rdata = mem[mem_addr]; rf_n++; last_rf_addr = mem_addr;
        end
      end
    end else mcnt = 0;
  end

  // One CPU access: holds the request until miss drops, lets the hit edge pass, then releases.
  task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic fm, output int cyc);
    chipSel = 1; write = w; addr = a; wdata = d;
    #1; fm = miss; cyc = 0;
    while (miss && cyc < 40) begin @(negedge clk); cyc++; end
    if (miss) begin total++; bad++; $display("FAIL access_timeout addr=%0d", a); end
    rd = rdata;
    @(negedge clk); chipSel = 0; write = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; @(negedge clk); @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    do_reset(); addr = 0; #1;
    total++; if (miss !== 1'b0) begin bad++; $display("FAIL rst_miss got=%b exp=0", miss); end
    total++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL rst_req got=%b%b exp=00", mem_req, mem_we); end
    total++; if (mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_maddr got=%0d/%0d exp=0/0", mem_addr, mem_wdata); end
    total++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%0d exp=0", rdata); end
  endtask

  task automatic test_load_miss();
    logic [31:0] rd; logic fm; int cyc;
    access(0, 8'd1, 0, rd, fm, cyc);
    total++; if (fm !== 1'b1) begin bad++; $display("FAIL ld_first_miss got=%b exp=1", fm); end
    total++; if (cyc != 3) begin bad++; $display("FAIL ld_penalty got=%0d exp=3", cyc); end
    total++; if (rd !== 32'd15) begin bad++; $display("FAIL ld_rdata got=%0d exp=15", rd); end
    total++; if (rf_n != 1 || wb_n != 0 || last_rf_addr !== 8'd1) begin bad++; $display("FAIL ld_mem got rf=%0d wb=%0d a=%0d exp 1/0/1", rf_n, wb_n, last_rf_addr); end
    total++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin bad++; $display("FAIL ld_cnt got=%0d/%0d exp=1/1", hit_cnt, miss_cnt); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ld_req_low got=%b exp=0", mem_req); end
  endtask

  task automatic test_store_cold();
    logic [31:0] rd; logic fm; int cyc;
    access(1, 8'd2, 32'd14, rd, fm, cyc);
    total++; if (fm !== 1'b1) begin bad++; $display("FAIL st_miss got=%b exp=1", fm); end
    total++; if (rf_n != 2 || wb_n != 0 || last_rf_addr !== 8'd2) begin bad++; $display("FAIL st_mem got rf=%0d wb=%0d a=%0d exp 2/0/2", rf_n, wb_n, last_rf_addr); end
    access(0, 8'd2, 0, rd, fm, cyc);
    total++; if (fm !== 1'b0) begin bad++; $display("FAIL st_reload_hit got_miss=%b exp=0", fm); end
    total++; if (rd !== 32'd14) begin bad++; $display("FAIL st_reload_data got=%0d exp=14", rd); end
    total++; if (hit_cnt !== 16'd3 || miss_cnt !== 16'd2) begin bad++; $display("FAIL st_cnt got=%0d/%0d exp=3/2", hit_cnt, miss_cnt); end
  endtask

  task automatic test_dirty_conflict();
    logic [31:0] rd; logic fm; int cyc;
    access(0, 8'd34, 0, rd, fm, cyc);
    total++; if (wb_n != 1 || last_wb_addr !== 8'd2 || last_wb_data !== 32'd14) begin bad++; $display("FAIL wb_txn got n=%0d a=%0d d=%0d exp 1/2/14", wb_n, last_wb_addr, last_wb_data); end
    total++; if (rf_n != 3 || last_rf_addr !== 8'd34) begin bad++; $display("FAIL wb_refill got n=%0d a=%0d exp 3/34", rf_n, last_rf_addr); end
    total++; if (cyc != 6) begin bad++; $display("FAIL wb_penalty got=%0d exp=6", cyc); end
    total++; if (rd !== 32'd134) begin bad++; $display("FAIL wb_rdata got=%0d exp=134", rd); end
    total++; if (miss_cnt !== 16'd3 || hit_cnt !== 16'd4) begin bad++; $display("FAIL wb_cnt got=%0d/%0d exp=4/3", hit_cnt, miss_cnt); end
  endtask

  task automatic test_clean_conflict();
    logic [31:0] rd; logic fm; int cyc;
    access(0, 8'd1, 0, rd, fm, cyc);
    total++; if (fm !== 1'b0 || rd !== 32'd15) begin bad++; $display("FAIL cc_hit1 got miss=%b d=%0d exp 0/15", fm, rd); end
    access(0, 8'd17, 0, rd, fm, cyc);
    total++; if (fm !== 1'b1 || rd !== 32'd117 || wb_n != 1 || last_rf_addr !== 8'd17) begin bad++; $display("FAIL cc_17 got miss=%b d=%0d wb=%0d a=%0d exp 1/117/1/17", fm, rd, wb_n, last_rf_addr); end
    access(0, 8'd1, 0, rd, fm, cyc);
    total++; if (fm !== 1'b1 || rd !== 32'd15 || wb_n != 1) begin bad++; $display("FAIL cc_reload got miss=%b d=%0d wb=%0d exp 1/15/1", fm, rd, wb_n); end
    total++; if (hit_cnt !== 16'd7 || miss_cnt !== 16'd5) begin bad++; $display("FAIL cc_cnt got=%0d/%0d exp=7/5", hit_cnt, miss_cnt); end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] rd; logic fm; int cyc;
    access(0, 8'd255, 0, rd, fm, cyc);
    total++; if (rd !== 32'd355 || last_rf_addr !== 8'd255) begin bad++; $display("FAIL wrap_top got d=%0d a=%0d exp 355/255", rd, last_rf_addr); end
    access(0, 8'd0, 0, rd, fm, cyc);
    total++; if (rd !== 32'd100 || last_rf_addr !== 8'd0) begin bad++; $display("FAIL wrap_zero got d=%0d a=%0d exp 100/0", rd, last_rf_addr); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic fm; int cyc;
    model_en = 0;
    chipSel = 1; write = 0; addr = 8'd5;
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'd5) begin bad++; $display("FAIL rm_req got=%b a=%0d exp 1/5", mem_req, mem_addr); end
    @(negedge clk); rst = 1; chipSel = 0;
    @(negedge clk); rst = 0;
    total++; if (mem_req !== 1'b0 || miss !== 1'b0) begin bad++; $display("FAIL rm_abort got req=%b miss=%b exp 0/0", mem_req, miss); end
    mem_ack = 1; mem_rdata = 32'd999;
    @(negedge clk); mem_ack = 0;
    total++; if (mem_req !== 1'b0 || miss !== 1'b0) begin bad++; $display("FAIL rm_late_ack got req=%b miss=%b exp 0/0", mem_req, miss); end
    total++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin bad++; $display("FAIL rm_cnt got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    model_en = 1;
    access(0, 8'd5, 0, rd, fm, cyc);
    total++; if (fm !== 1'b1 || rd !== 32'd105) begin bad++; $display("FAIL rm_no_fill got miss=%b d=%0d exp 1/105", fm, rd); end
    access(0, 8'd1, 0, rd, fm, cyc);
    total++; if (fm !== 1'b1 || rd !== 32'd15) begin bad++; $display("FAIL rm_invalid got miss=%b d=%0d exp 1/15", fm, rd); end
  endtask

  task automatic test_saturation();
    logic [31:0] rd; logic fm; int cyc;
    do_reset();
    for (int i = 0; i < 5; i++) access(0, 8'd3, 0, rd, fm, cyc);
    total++; if (s_hit_cnt !== 2'd3 || s_miss_cnt !== 2'd1) begin bad++; $display("FAIL sat_cnt got=%0d/%0d exp=3/1", s_hit_cnt, s_miss_cnt); end
    total++; if (hit_cnt !== 16'd5 || miss_cnt !== 16'd1) begin bad++; $display("FAIL sat_wide got=%0d/%0d exp=5/1", hit_cnt, miss_cnt); end
    total++; if (s_rdata !== 32'd103) begin bad++; $display("FAIL sat_rdata got=%0d exp=103", s_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i + 100;
    mem[1] = 32'd15;
    test_reset();
    test_load_miss();
    test_store_cold();
    test_dirty_conflict();
    test_clean_conflict();
    test_addr_wrap();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
